// File: rtl/line_stream_sequencer.sv
// Raster-stream sequencer feeding the one-line delay FIFO (clken/enable/din side).
// Define LINE_FLUSH_EN to append one line of FLUSH_DATA strobes that drains the FIFO at frame end.
module line_stream_sequencer #(
   parameter int unsigned DWIDTH = 18,
   parameter int unsigned CWIDTH = 11,
   parameter int unsigned RWIDTH = 11
`ifdef LINE_FLUSH_EN
   ,
   parameter logic [DWIDTH-1:0] FLUSH_DATA = '0
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CWIDTH-1:0] width,
   input  logic [RWIDTH-1:0] height,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              clken,
   output logic              enable,
   output logic [DWIDTH-1:0] dout,
   output logic              eol,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state, state_n;
   logic [CWIDTH-1:0] col, col_n;
   logic [RWIDTH-1:0] row, row_n;
   logic [CWIDTH-1:0] width_r, width_n;
   logic [RWIDTH-1:0] height_r, height_n;
   logic              clken_n, enable_n, eol_n, busy_n, done_n;
   logic [DWIDTH-1:0] dout_n;
   logic              accept;
   logic              col_last;
   logic              row_last;
`ifdef LINE_FLUSH_EN
   logic [CWIDTH-1:0] flush_cnt, flush_n;
`endif

   assign in_ready = (state == S_STREAM);
   assign accept   = in_ready & in_valid;
   assign col_last = (col == width_r - CWIDTH'(1));
   assign row_last = (row == height_r - RWIDTH'(1));

   always_comb begin
      state_n  = state;
      col_n    = col;
      row_n    = row;
      width_n  = width_r;
      height_n = height_r;
      clken_n  = 1'b0;
      eol_n    = 1'b0;
      enable_n = enable;
      dout_n   = dout;
      done_n   = 1'b0;
`ifdef LINE_FLUSH_EN
      flush_n  = flush_cnt;
`endif
      case (state)
         S_IDLE: begin
            enable_n = 1'b0;
            if (start && (width > CWIDTH'(1)) && (height != '0)) begin
               width_n  = width;
               height_n = height;
               col_n    = '0;
               row_n    = '0;
               state_n  = S_STREAM;
            end
         end
         S_STREAM: begin
            if (accept) begin
               clken_n  = 1'b1;
               dout_n   = in_data;
               eol_n    = col_last;
               enable_n = (row != '0);
               if (col_last) begin
                  col_n = '0;
                  row_n = row + RWIDTH'(1);
                  if (row_last) begin
`ifdef LINE_FLUSH_EN
                     flush_n = '0;
                     state_n = S_FLUSH;
`else
                     state_n = S_DONE;
`endif
                  end
               end else begin
                  col_n = col + CWIDTH'(1);
               end
            end
         end
`ifdef LINE_FLUSH_EN
         S_FLUSH: begin
            clken_n  = 1'b1;
            dout_n   = FLUSH_DATA;
            enable_n = 1'b1;
            if (flush_cnt == width_r - CWIDTH'(1)) begin
               eol_n   = 1'b1;
               flush_n = '0;
               state_n = S_DONE;
            end else begin
               flush_n = flush_cnt + CWIDTH'(1);
            end
         end
`endif
         S_DONE: begin
            done_n   = 1'b1;
            enable_n = 1'b0;
            state_n  = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // busy covers the cycle of the final strobe; it drops together with the done pulse
      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         col      <= '0;
         row      <= '0;
         width_r  <= '0;
         height_r <= '0;
         clken    <= 1'b0;
         enable   <= 1'b0;
         dout     <= '0;
         eol      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef LINE_FLUSH_EN
         flush_cnt <= '0;
`endif
      end else begin
         state    <= state_n;
         col      <= col_n;
         row      <= row_n;
         width_r  <= width_n;
         height_r <= height_n;
         clken    <= clken_n;
         enable   <= enable_n;
         dout     <= dout_n;
         eol      <= eol_n;
         busy     <= busy_n;
         done     <= done_n;
`ifdef LINE_FLUSH_EN
         flush_cnt <= flush_n;
`endif
      end
   end

endmodule

// File: tb/tb_line_stream_sequencer.sv
// Directed bench for line_stream_sequencer: scoreboard of expected strobes, checked with immediate assertions.
module tb_line_stream_sequencer;

   localparam int DW = 18;
   localparam int CW = 11;
   localparam int RW = 11;
`ifdef LINE_FLUSH_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] width;
   logic [RW-1:0] height;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          clken;
   logic          enable;
   logic [DW-1:0] dout;
   logic          eol;
   logic          busy;
   logic          done;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          eol;
      logic          en;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   strobes  = 0;
   int   done_cnt = 0;
   bit   mon_en   = 1'b0;

   line_stream_sequencer #(.DWIDTH(DW), .CWIDTH(CW), .RWIDTH(RW)) dut (
      .clk(clk), .rst(rst), .width(width), .height(height), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .clken(clken), .enable(enable), .dout(dout), .eol(eol),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (clken === 1'b1) begin
            strobes++;
            chk("strobe_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("dout", 64'(dout), 64'(e.d));
               chk("eol", 64'(eol), 64'(e.eol));
               chk("enable", 64'(enable), 64'(e.en));
            end
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic do_start(input int w, input int h, input bit legal);
      width    = CW'(w);
      height   = RW'(h);
      start    = 1'b1;
      in_valid = 1'b1;
      chk("idle_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      chk("start_busy", 64'(busy), 64'(legal));
      chk("start_clken", 64'(clken), 64'(0));
   endtask

   task automatic send(input logic [DW-1:0] d, input logic e_eol, input logic e_en);
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      chk("in_ready", 64'(in_ready), 64'(1));
      e.d   = d;
      e.eol = e_eol;
      e.en  = e_en;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic frame(input int w, input int h, input bit gaps, input int poke);
      int s0;
      int d0;
      int k;
      exp_t f;
      logic [DW-1:0] d;
      k = 0;
      do_start(w, h, 1'b1);
      s0 = strobes;
      d0 = done_cnt;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            if (gaps && k != 0) begin
               @(posedge clk); #1;
               chk("gap_clken", 64'(clken), 64'(0));
            end
            if (k == poke) begin
               start  = 1'b1;
               width  = CW'(2);
               height = RW'(1);
            end
            d = DW'($urandom);
            send(d, (c == w - 1), (r >= 1));
            start  = 1'b0;
            width  = CW'(w);
            height = RW'(h);
            k++;
         end
      end
      for (int i = 0; i < w * FL; i++) begin
         f.d   = '0;
         f.eol = (i == w - 1);
         f.en  = 1'b1;
         sb.push_back(f);
      end
      chk("last_strobe_done", 64'(done), 64'(0));
      for (int j = 0; j < w * FL; j++) begin
         @(posedge clk); #1;
         chk("flush_done", 64'(done), 64'(0));
      end
      @(posedge clk); #1;
      chk("done_pulse", 64'(done), 64'(1));
      chk("done_busy", 64'(busy), 64'(0));
      chk("done_clken", 64'(clken), 64'(0));
      @(posedge clk); #1;
      chk("after_done", 64'(done), 64'(0));
      chk("after_in_ready", 64'(in_ready), 64'(0));
      chk("sb_empty", 64'(sb.size()), 64'(0));
      chk("strobe_count", 64'(strobes - s0), 64'(w * h + FL * w));
      chk("done_count", 64'(done_cnt - d0), 64'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      int d0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      width    = '0;
      height   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_clken", 64'(clken), 64'(0));
      chk("rst_enable", 64'(enable), 64'(0));
      chk("rst_dout", 64'(dout), 64'(0));
      chk("rst_eol", 64'(eol), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));

      frame(4, 3, 1'b0, -1);
      frame(4, 2, 1'b1, -1);

      s0 = strobes;
      d0 = done_cnt;
      do_start(1, 3, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      do_start(4, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("illegal_busy", 64'(busy), 64'(0));
      chk("illegal_strobes", 64'(strobes - s0), 64'(0));
      chk("illegal_done", 64'(done_cnt - d0), 64'(0));

      do_start(8, 4, 1'b1);
      for (int k = 0; k < 9; k++) send(DW'($urandom), (k % 8 == 7), (k >= 8));
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      rst      = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("midrst_clken", 64'(clken), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      s0 = strobes;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
      chk("midrst_no_strobe", 64'(strobes - s0), 64'(0));
      chk("midrst_sb_empty", 64'(sb.size()), 64'(0));
      frame(4, 1, 1'b0, -1);

      frame(4, 2, 1'b0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
